// File: rtl/rv32i_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared types and constants for the rv32i pipeline (fetch-stage subset).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam int DPW = 32;

   localparam logic [31:0]    NOP_INSTR        = 32'h0000_0013;
   localparam logic [DPW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // REQ: request presented, WAIT: granted and awaiting the response,
   // DROP: awaiting a response that a redirect made stale,
   // HOLD: response parked in the buffer while decode is stalled.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Priority: flush > stall > load.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module if_id_reg
   import rv32i_pkg::*;
(
   input  logic           clk_i,
   input  logic           arst_ni,
   input  logic           flush_i,
   input  logic           stall_i,
   input  logic           load_i,
   input  logic [31:0]    instr_i,
   input  logic [DPW-1:0] pc_i,
   output logic [31:0]    instr_o,
   output logic [DPW-1:0] pc_o,
   output logic           valid_o
);

   // Flush wipes the entry to a NOP; stall holds; load captures a new fetch.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         instr_o <= NOP_INSTR;
         pc_o    <= '0;
         valid_o <= 1'b0;
      end else if (flush_i) begin
         instr_o <= NOP_INSTR;
         valid_o <= 1'b0;
      end else if (!stall_i && load_i) begin
         instr_o <= instr_i;
         pc_o    <= pc_i;
         valid_o <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit
//   rv32i instruction-fetch stage: PCF register, imem req/gnt/rvalid
//   handshake, one-entry response buffer for decode stalls, redirect drop.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [DPW-1:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic           clk_i,
   input  logic           arst_ni,
   input  logic [DPW-1:0] PCNext_i,
   input  logic           PCsrc_i,
   input  logic           stallD_i,
   input  logic           flushD_i,
   output logic [DPW-1:0] PCF_o,
   output logic           imem_req_o,
   output logic [DPW-1:0] imem_addr_o,
   input  logic           imem_gnt_i,
   input  logic           imem_rvalid_i,
   input  logic [31:0]    imem_rdata_i,
   output logic [31:0]    instrD_o,
   output logic [DPW-1:0] PCD_o,
   output logic           validD_o,
   output logic           misalignF_o
);

   fetch_state_t   state_q, state_d;
   logic [DPW-1:0] inflight_q;
   logic [31:0]    buf_q;
   logic           live_q;
   logic           misalign_q;

   logic           pc_load;
   logic           inflight_load;
   logic           buf_load;
   logic           ifid_load;
   logic [31:0]    ifid_data;
   logic           req;

   // FSM state, PC, in-flight address, buffer and misalign flag registers.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q    <= REQ;
         PCF_o      <= RESET_PC;
         inflight_q <= '0;
         buf_q      <= '0;
         live_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         live_q     <= 1'b1;
         misalign_q <= pc_load && (PCNext_i[1:0] != 2'b00);
         if (pc_load)
            PCF_o <= {PCNext_i[DPW-1:2], 2'b00};
         if (inflight_load)
            inflight_q <= PCF_o;
         if (buf_load)
            buf_q <= imem_rdata_i;
      end
   end

   // Next-state and datapath enables; a redirect always reloads the PC.
   always_comb begin
      state_d       = state_q;
      pc_load       = 1'b0;
      inflight_load = 1'b0;
      buf_load      = 1'b0;
      ifid_load     = 1'b0;
      ifid_data     = imem_rdata_i;
      req           = 1'b0;
      case (state_q)
         REQ: begin
            req = 1'b1;
            if (imem_gnt_i) begin
               inflight_load = 1'b1;
               // A grant coinciding with a redirect fetches a stale address.
               state_d = PCsrc_i ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (PCsrc_i) begin
                  state_d = REQ;
               end else if (!stallD_i) begin
                  ifid_load = 1'b1;
                  pc_load   = 1'b1;
                  state_d   = REQ;
               end else begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end
            end else if (PCsrc_i) begin
               state_d = DROP;
            end
         end
         HOLD: begin
            if (PCsrc_i) begin
               state_d = REQ;
            end else if (!stallD_i) begin
               ifid_load = 1'b1;
               ifid_data = buf_q;
               pc_load   = 1'b1;
               state_d   = REQ;
            end
         end
         DROP: begin
            if (imem_rvalid_i)
               state_d = REQ;
         end
         default: state_d = REQ;
      endcase
      if (PCsrc_i)
         pc_load = 1'b1;
   end

   assign imem_req_o  = req && live_q;
   assign imem_addr_o = PCF_o;
   assign misalignF_o = misalign_q;

   if_id_reg u_if_id_reg (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .flush_i (flushD_i || PCsrc_i),
      .stall_i (stallD_i),
      .load_i  (ifid_load),
      .instr_i (ifid_data),
      .pc_i    (inflight_q),
      .instr_o (instrD_o),
      .pc_o    (PCD_o),
      .valid_o (validD_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed self-checking bench for fetch_unit.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [31:0] target;
   logic [31:0] pcnext;
   logic        pcsrc, stall, flush;
   logic [31:0] pcf, addr, instr, pcd;
   logic        req, gnt, rvalid, valid, mis;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Surrounding next-PC logic: sequential PC or redirect target.
   assign pcnext = pcsrc ? target : pcf + 32'd4;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk_i         (clk),
      .arst_ni       (arst_n),
      .PCNext_i      (pcnext),
      .PCsrc_i       (pcsrc),
      .stallD_i      (stall),
      .flushD_i      (flush),
      .PCF_o         (pcf),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .instrD_o      (instr),
      .PCD_o         (pcd),
      .validD_o      (valid),
      .misalignF_o   (mis)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch with same-cycle grant and next-cycle response.
   task automatic fetch(input logic [31:0] word);
      gnt = 1'b1;
      tick();
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = word;
      tick();
      rvalid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; target = '0;
      #2 arst_n = 1'b0;
      #1;
      check("rst_pcf",   pcf,   32'h0);
      check("rst_req",   {31'b0, req},   32'h0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pcd",   pcd,   32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_mis",   {31'b0, mis},   32'h0);
      #5 arst_n = 1'b1;
      tick();
      check("t1_req",  {31'b0, req}, 32'h1);
      check("t1_addr", addr, 32'h0);

      // 1: first fetch
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      check("t1_wait_req", {31'b0, req}, 32'h0);
      rvalid = 1'b1; rdata = 32'h0050_0093;
      tick();
      rvalid = 1'b0;
      check("t1_instr", instr, 32'h0050_0093);
      check("t1_pcd",   pcd,   32'h0);
      check("t1_valid", {31'b0, valid}, 32'h1);
      check("t1_pcf",   pcf,   32'h4);
      check("t1_addr4", addr,  32'h4);
      fetch(32'h0010_0113);
      check("pc4_pcd", pcd, 32'h4);
      check("pc4_pcf", pcf, 32'h8);

      // 2: stall while the PC 8 response arrives
      gnt = 1'b1;
      tick();
      gnt = 1'b0; stall = 1'b1; rvalid = 1'b1; rdata = 32'h0020_8133;
      tick();
      rvalid = 1'b0;
      check("t2_hold_instr", instr, 32'h0010_0113);
      check("t2_hold_pcd",   pcd,   32'h4);
      check("t2_hold_pcf",   pcf,   32'h8);
      check("t2_hold_req",   {31'b0, req}, 32'h0);
      tick();
      tick();
      check("t2_hold_pcf3",  pcf,   32'h8);
      check("t2_hold_valid", {31'b0, valid}, 32'h1);
      stall = 1'b0;
      tick();
      check("t2_instr", instr, 32'h0020_8133);
      check("t2_pcd",   pcd,   32'h8);
      check("t2_pcf",   pcf,   32'hC);
      check("t2_req",   {31'b0, req}, 32'h1);

      // 3: redirect while waiting on PC 0x10
      fetch(32'h0000_0013);
      check("t3_pcf10", pcf, 32'h10);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; pcsrc = 1'b1; target = 32'h100;
      tick();
      pcsrc = 1'b0;
      check("t3_valid", {31'b0, valid}, 32'h0);
      check("t3_pcf",   pcf, 32'h100);
      check("t3_req",   {31'b0, req}, 32'h0);
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      rvalid = 1'b0;
      check("t3_drop_valid", {31'b0, valid}, 32'h0);
      check("t3_drop_instr", instr, 32'h0000_0013);
      check("t3_req2",  {31'b0, req}, 32'h1);
      check("t3_addr",  addr, 32'h100);

      // 4: flush overrides stall
      fetch(32'h00A0_0193);
      check("t4_pre_valid", {31'b0, valid}, 32'h1);
      check("t4_pre_pcd",   pcd, 32'h100);
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      check("t4_valid", {31'b0, valid}, 32'h0);
      check("t4_instr", instr, 32'h0000_0013);
      check("t4_pcf",   pcf, 32'h104);

      // 5: misaligned PC load
      pcsrc = 1'b1; target = 32'h102;
      tick();
      pcsrc = 1'b0;
      check("t5_pcf", pcf, 32'h100);
      check("t5_mis", {31'b0, mis}, 32'h1);
      tick();
      check("t5_mis_clr", {31'b0, mis}, 32'h0);

      // PC wrap at the top of the address space
      pcsrc = 1'b1; target = 32'hFFFF_FFFC;
      tick();
      pcsrc = 1'b0;
      check("wrap_mis0", {31'b0, mis}, 32'h0);
      fetch(32'h0000_0013);
      check("wrap_pcf", pcf, 32'h0);
      check("wrap_pcd", pcd, 32'hFFFF_FFFC);
      check("wrap_mis", {31'b0, mis}, 32'h0);

      // 6: reset mid-WAIT at PC 0x40
      pcsrc = 1'b1; target = 32'h40;
      tick();
      pcsrc = 1'b0;
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      check("t6_pcf40", pcf, 32'h40);
      check("t6_wait",  {31'b0, req}, 32'h0);
      #2 arst_n = 1'b0;
      #1;
      check("t6_rst_pcf",   pcf, 32'h0);
      check("t6_rst_req",   {31'b0, req}, 32'h0);
      check("t6_rst_valid", {31'b0, valid}, 32'h0);
      check("t6_rst_instr", instr, 32'h0000_0013);
      check("t6_rst_pcd",   pcd, 32'h0);
      tick();
      arst_n = 1'b1;
      tick();
      check("t6_req",  {31'b0, req}, 32'h1);
      check("t6_addr", addr, 32'h0);
      fetch(32'h0030_0213);
      check("t6_instr", instr, 32'h0030_0213);
      check("t6_pcd",   pcd, 32'h0);
      check("t6_valid", {31'b0, valid}, 32'h1);
      check("t6_pcf",   pcf, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
